// File: rtl/axis_tx_arbiter.sv
// N:1 round-robin packet arbiter for AXI-Stream sources. The grant is held from the first beat through the accepted tlast beat.
// Define PKT_LEN_EN to report each forwarded packet's byte length and source port.
module axis_tx_arbiter #(
  parameter int N_PORTS = 2,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 16,
  localparam int GW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int KW     = DATA_W / 8
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  input  logic [N_PORTS-1:0]        s_axis_tvalid,
  output logic [N_PORTS-1:0]        s_axis_tready,
  input  logic [N_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [N_PORTS*KW-1:0]     s_axis_tkeep,
  input  logic [N_PORTS-1:0]        s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [KW-1:0]             m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [GW-1:0]             grant_port,
  output logic                      busy,
  output logic                      pkt_len_valid,
  output logic [LEN_W-1:0]          pkt_len_bytes,
  output logic [GW-1:0]             pkt_len_port
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg;
  logic [GW-1:0]     grant_reg;
  logic [DATA_W-1:0] port_data [N_PORTS];
  logic [KW-1:0]     port_keep [N_PORTS];
  logic              in_busy;
  logic              beat_acc;
  logic              beat_last;
  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  int                idx;

  assign in_busy = (state_reg == BUSY);

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign port_data[gi]     = s_axis_tdata[gi*DATA_W +: DATA_W];
      assign port_keep[gi]     = s_axis_tkeep[gi*KW +: KW];
      assign s_axis_tready[gi] = in_busy && (grant_reg == GW'(gi)) && m_axis_tready;
    end
  endgenerate

  // Pass-through of the granted port; outputs are forced to zero outside a grant.
  assign m_axis_tvalid = in_busy && s_axis_tvalid[grant_reg];
  assign m_axis_tdata  = in_busy ? port_data[grant_reg] : '0;
  assign m_axis_tkeep  = in_busy ? port_keep[grant_reg] : '0;
  assign m_axis_tlast  = in_busy && s_axis_tlast[grant_reg];

  assign beat_acc   = m_axis_tvalid && m_axis_tready;
  assign beat_last  = beat_acc && m_axis_tlast;
  assign grant_port = grant_reg;
  assign busy       = in_busy;

  // Scan from the farthest candidate back toward grant+1, so the nearest requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_reg;
    idx        = 0;
    for (int k = N_PORTS; k >= 1; k--) begin
      idx = int'(grant_reg) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (s_axis_tvalid[GW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_reg <= IDLE;
      grant_reg <= GW'(N_PORTS - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg <= pick_idx;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (beat_last) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef PKT_LEN_EN
  localparam int CW = $clog2(KW) + 1;

  logic [LEN_W-1:0] acc_reg;
  logic [LEN_W-1:0] pkt_bytes_reg;
  logic [GW-1:0]    pkt_port_reg;
  logic             pkt_valid_reg;
  logic [CW-1:0]    keep_cnt;
  logic [LEN_W:0]   sum_wide;
  logic [LEN_W-1:0] sum_sat;

  assign keep_cnt = CW'($countones(m_axis_tkeep));
  assign sum_wide = {1'b0, acc_reg} + {{(LEN_W + 1 - CW){1'b0}}, keep_cnt};
  // Clamp at all-ones rather than wrapping on very long packets.
  assign sum_sat  = sum_wide[LEN_W] ? {LEN_W{1'b1}} : sum_wide[LEN_W-1:0];

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      acc_reg       <= '0;
      pkt_bytes_reg <= '0;
      pkt_port_reg  <= '0;
      pkt_valid_reg <= 1'b0;
    end else begin
      pkt_valid_reg <= 1'b0;
      if (beat_acc) begin
        if (m_axis_tlast) begin
          acc_reg       <= '0;
          pkt_valid_reg <= 1'b1;
          pkt_bytes_reg <= sum_sat;
          pkt_port_reg  <= grant_reg;
        end else begin
          acc_reg <= sum_sat;
        end
      end
    end
  end

  assign pkt_len_valid = pkt_valid_reg;
  assign pkt_len_bytes = pkt_bytes_reg;
  assign pkt_len_port  = pkt_port_reg;
`else
  assign pkt_len_valid = 1'b0;
  assign pkt_len_bytes = '0;
  assign pkt_len_port  = '0;
`endif

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Randomised bench for axis_tx_arbiter with 4 ports. A spec-level model is checked against the DUT every cycle.
// Directed scenarios add literal checks on packet order, beat counts and byte counts.
module tb_axis_tx_arbiter;
  localparam int NP   = 4;
  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int LW   = 10;
  localparam int LMAX = (1 << LW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     s_valid = '0;
  logic [NP-1:0]     s_ready;
  logic [NP*DW-1:0]  s_data = '0;
  logic [NP*KW-1:0]  s_keep = '0;
  logic [NP-1:0]     s_last = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DW-1:0]     m_data;
  logic [KW-1:0]     m_keep;
  logic              m_last;
  logic [1:0]        grant_port;
  logic              busy;
  logic              pkt_len_valid;
  logic [LW-1:0]     pkt_len_bytes;
  logic [1:0]        pkt_len_port;

  axis_tx_arbiter #(.N_PORTS(NP), .DATA_W(DW), .LEN_W(LW)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .grant_port(grant_port), .busy(busy),
    .pkt_len_valid(pkt_len_valid), .pkt_len_bytes(pkt_len_bytes), .pkt_len_port(pkt_len_port)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int valid_pct = 100;
  int ready_pct = 100;
  int ready_mode = 0;

  logic [72:0] pq [NP][$];
  int port_log[$];
  int beat_log[$];
  int byte_log[$];
  int len_log[$];
  logic [63:0] dlog[$];
  int cur_beats = 0;
  int cur_bytes = 0;

  // Reference model state: grant flag, granted port, byte total, report registers.
  bit mb;
  int mg;
  int macc;
  bit mpv;
  int mpb;
  int mpp;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int next_grant(logic [NP-1:0] v, int g);
    for (int k = 1; k <= NP; k++)
      if (v[(g + k) % NP]) return (g + k) % NP;
    return -1;
  endfunction

  function automatic int sat_add(int a, int b);
    return (a + b > LMAX) ? LMAX : a + b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb <= 1'b0; mg <= NP - 1; macc <= 0; mpv <= 1'b0; mpb <= 0; mpp <= 0;
    end else begin
      mpv <= 1'b0;
      if (!mb) begin
        if (next_grant(s_valid, mg) >= 0) begin
          mg <= next_grant(s_valid, mg);
          mb <= 1'b1;
        end
      end else if (s_valid[mg] && m_ready) begin
        if (s_last[mg]) begin
          mb <= 1'b0; macc <= 0; mpv <= 1'b1; mpp <= mg;
          mpb <= sat_add(macc, $countones(s_keep[mg*KW +: KW]));
        end else begin
          macc <= sat_add(macc, $countones(s_keep[mg*KW +: KW]));
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus packet logging from the DUT's master side.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(mb));
      check("grant_port", 64'(grant_port), 64'(mg));
      check("s_tready", 64'(s_ready), (mb && m_ready) ? 64'(1) << mg : 64'd0);
      check("m_tvalid", 64'(m_valid), mb ? 64'(s_valid[mg]) : 64'd0);
      if (mb && s_valid[mg]) begin
        check("m_tdata", m_data, s_data[mg*DW +: DW]);
        check("m_tkeep", 64'(m_keep), 64'(s_keep[mg*KW +: KW]));
        check("m_tlast", 64'(m_last), 64'(s_last[mg]));
      end
`ifdef PKT_LEN_EN
      check("pkt_len_valid", 64'(pkt_len_valid), 64'(mpv));
      check("pkt_len_bytes", 64'(pkt_len_bytes), 64'(mpb));
      check("pkt_len_port", 64'(pkt_len_port), 64'(mpp));
`else
      check("pkt_len_valid", 64'(pkt_len_valid), 64'd0);
      check("pkt_len_bytes", 64'(pkt_len_bytes), 64'd0);
      check("pkt_len_port", 64'(pkt_len_port), 64'd0);
`endif
      if (!rst_n) begin
        cur_beats <= 0;
        cur_bytes <= 0;
      end else if (m_valid && m_ready) begin
        dlog.push_back(m_data);
        if (m_last) begin
          port_log.push_back(int'(grant_port));
          beat_log.push_back(cur_beats + 1);
          byte_log.push_back(cur_bytes + $countones(m_keep));
          cur_beats <= 0;
          cur_bytes <= 0;
        end else begin
          cur_beats <= cur_beats + 1;
          cur_bytes <= cur_bytes + $countones(m_keep);
        end
      end
      if (rst_n && pkt_len_valid) len_log.push_back(int'(pkt_len_bytes));
    end
  end

  task automatic step();
    logic [NP-1:0] hs;
    @(negedge clk);
    hs = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (hs[i]) void'(pq[i].pop_front());
      if (!(s_valid[i] && !hs[i])) begin
        if (pq[i].size() > 0 && $urandom_range(99) < valid_pct) begin
          s_valid[i] = 1'b1;
          {s_last[i], s_keep[i*KW +: KW], s_data[i*DW +: DW]} = pq[i][0];
        end else begin
          s_valid[i] = 1'b0;
          s_last[i] = 1'($urandom);
          s_keep[i*KW +: KW] = 8'($urandom);
          s_data[i*DW +: DW] = {$urandom, $urandom};
        end
      end
    end
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = ($urandom_range(99) < ready_pct);
    endcase
  endtask

  task automatic add_pkt(input int port, input int nb, input logic [7:0] body_keep,
                         input logic [7:0] last_keep, input bit rnd);
    for (int i = 0; i < nb; i++) begin
      logic [7:0] k;
      logic [63:0] d;
      k = (i == nb - 1) ? last_keep : body_keep;
      d = {32'(port), 32'(i)};
      if (rnd) begin
        k = 8'($urandom);
        d = {$urandom, $urandom};
      end
      pq[port].push_back({(i == nb - 1), k, d});
    end
  endtask

  task automatic clear_logs();
    port_log.delete(); beat_log.delete(); byte_log.delete(); len_log.delete(); dlog.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < NP; i++) pq[i].delete();
    s_valid = '0;
    s_last = '0;
    repeat (cycles) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int c;
    bit pend;
    c = 0;
    pend = 1'b1;
    while (pend && c < budget) begin
      step();
      c++;
      pend = mb;
      for (int i = 0; i < NP; i++) if (pq[i].size() > 0) pend = 1'b1;
    end
    check(nm, 64'(c < budget), 64'd1);
    repeat (3) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    chk_en = 1'b1;
    check("rst_grant", 64'(grant_port), 64'd3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_tready", 64'(s_ready), 64'd0);
    check("rst_m_tvalid", 64'(m_valid), 64'd0);
    check("rst_pkt_len_bytes", 64'(pkt_len_bytes), 64'd0);

    // 21-beat packet on port 0: 20 full words plus a 4-byte tail.
    clear_logs();
    add_pkt(0, 21, 8'hff, 8'h0f, 1'b0);
    wait_drain("t1_drain", 500);
    check("t1_npkt", 64'(port_log.size()), 64'd1);
    if (port_log.size() >= 1) begin
      check("t1_port", 64'(port_log[0]), 64'd0);
      check("t1_beats", 64'(beat_log[0]), 64'd21);
      check("t1_bytes", 64'(byte_log[0]), 64'd164);
    end
    for (int i = 0; i < dlog.size(); i++) check("t1_data", dlog[i], {32'd0, 32'(i)});
`ifdef PKT_LEN_EN
    check("t1_len_n", 64'(len_log.size()), 64'd1);
    if (len_log.size() >= 1) check("t1_len", 64'(len_log[0]), 64'd164);
`endif

    // Ports 0 and 1 request together straight out of reset.
    do_reset(2);
    clear_logs();
    add_pkt(0, 3, 8'hff, 8'hff, 1'b0);
    add_pkt(1, 3, 8'hff, 8'hff, 1'b0);
    wait_drain("t2_drain", 500);
    check("t2_npkt", 64'(port_log.size()), 64'd2);
    if (port_log.size() >= 2) begin
      check("t2_first", 64'(port_log[0]), 64'd0);
      check("t2_second", 64'(port_log[1]), 64'd1);
    end

    // Port 1 requests while a long port-0 packet is in flight.
    clear_logs();
    add_pkt(0, 42, 8'hff, 8'hff, 1'b0);
    repeat (6) step();
    add_pkt(1, 3, 8'hff, 8'h01, 1'b0);
    wait_drain("t3_drain", 500);
    check("t3_npkt", 64'(port_log.size()), 64'd2);
    if (port_log.size() >= 2) begin
      check("t3_first", 64'(port_log[0]), 64'd0);
      check("t3_first_beats", 64'(beat_log[0]), 64'd42);
      check("t3_second", 64'(port_log[1]), 64'd1);
      check("t3_second_bytes", 64'(byte_log[1]), 64'd17);
    end

    // Downstream ready toggles each cycle during a 4-beat packet.
    clear_logs();
    ready_mode = 1;
    add_pkt(2, 4, 8'hff, 8'h3f, 1'b0);
    wait_drain("t4_drain", 500);
    ready_mode = 0;
    check("t4_nbeats", 64'(dlog.size()), 64'd4);
    for (int i = 0; i < dlog.size(); i++) check("t4_data", dlog[i], {32'd2, 32'(i)});
    if (beat_log.size() >= 1) check("t4_bytes", 64'(byte_log[0]), 64'd30);

    // Reset lands in the middle of a 10-beat packet.
    clear_logs();
    add_pkt(0, 10, 8'hff, 8'hff, 1'b0);
    begin
      int g;
      g = 0;
      while (cur_beats < 3 && g < 200) begin step(); g++; end
      check("t5_reach_beat3", 64'(g < 200), 64'd1);
    end
    do_reset(2);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_no_len", 64'(len_log.size()), 64'd0);
    check("t5_no_pkt", 64'(port_log.size()), 64'd0);
    add_pkt(1, 2, 8'hff, 8'h0f, 1'b0);
    wait_drain("t5_drain", 500);
    if (byte_log.size() >= 1) check("t5_bytes", 64'(byte_log[0]), 64'd12);
`ifdef PKT_LEN_EN
    check("t5_len_n", 64'(len_log.size()), 64'd1);
    if (len_log.size() >= 1) check("t5_len", 64'(len_log[0]), 64'd12);
`endif

    // Ports 1 and 3 always requesting single-beat packets.
    do_reset(2);
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      add_pkt(1, 1, 8'hff, 8'hff, 1'b0);
      add_pkt(3, 1, 8'hff, 8'hff, 1'b0);
    end
    wait_drain("t6_drain", 500);
    check("t6_npkt", 64'(port_log.size()), 64'd8);
    for (int i = 0; i < port_log.size(); i++)
      check("t6_order", 64'(port_log[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

    // Randomised traffic: gaps on every source, random downstream backpressure.
    clear_logs();
    valid_pct = 70;
    ready_pct = 70;
    ready_mode = 2;
    for (int p = 0; p < 60; p++) add_pkt($urandom_range(NP - 1), $urandom_range(10, 1), 8'h00, 8'h00, 1'b1);
    wait_drain("rand_drain", 20000);
    check("rand_npkt", 64'(port_log.size()), 64'd60);
    valid_pct = 100;
    ready_mode = 0;

    // Byte counter saturation: 140 full beats = 1120 bytes.
    clear_logs();
    add_pkt(2, 140, 8'hff, 8'hff, 1'b0);
    wait_drain("sat_drain", 1000);
    if (byte_log.size() >= 1) check("sat_bytes", 64'(byte_log[0]), 64'd1120);
`ifdef PKT_LEN_EN
    if (len_log.size() >= 1) check("sat_len", 64'(len_log[0]), 64'(LMAX));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
